// File: rtl/msrh_conf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msrh_conf_pkg
//  Description : Core-level configuration constants shared by the dispatch
//                and branch-unit blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package msrh_conf_pkg;

    // Number of in-flight branches (one rename snapshot per branch)
    localparam int RV_BRU_ENTRY_SIZE = 16;
    // Instructions per dispatch group
    localparam int DISP_SIZE         = 2;

endpackage
`default_nettype wire

// File: rtl/msrh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msrh_pkg
//  Description : Common types for the branch-tag machinery: branch tag,
//                dispatch-group bit vector and the branch-update record that
//                travels on br_upd_if.
//  Revision    : 1.0  initial release
// ============================================================================
package msrh_pkg;

    localparam int BRTAG_NUM_DEF = msrh_conf_pkg::RV_BRU_ENTRY_SIZE;
    localparam int BRTAG_W       = $clog2(BRTAG_NUM_DEF);
    localparam int GRP_W         = msrh_conf_pkg::DISP_SIZE;

    typedef logic [BRTAG_W-1:0] brtag_t;
    typedef logic [GRP_W-1:0]   grp_id_t;

    // Fields carried by br_upd_if
    typedef struct packed {
        logic   update;      // a branch resolved this cycle
        brtag_t brtag;       // tag of that branch
        logic   mispredict;  // resolved against the prediction
    } br_upd_t;

endpackage
`default_nettype wire

// File: rtl/br_upd_if.sv
`default_nettype none
// ============================================================================
//  Module      : br_upd_if
//  Description : Branch resolution broadcast from the branch unit.
//                master : branch unit (drives)
//                slave  : consumers such as the tag allocator
//  Parameter   : TAG_W - branch tag width
//  Revision    : 1.0  initial release
// ============================================================================
interface br_upd_if #(
    parameter int TAG_W = msrh_pkg::BRTAG_W
);
    logic             update;
    logic [TAG_W-1:0] brtag;
    logic             mispredict;

    modport master (output update, output brtag, output mispredict);
    modport slave  (input  update, input  brtag, input  mispredict);
endinterface
`default_nettype wire

// File: rtl/msrh_brtag_offset.sv
`default_nettype none
// ============================================================================
//  Module      : msrh_brtag_offset
//  Description : Per-slot prefix popcount of a dispatch group's branch flags,
//                added to a base tag modulo BRTAG_NUM. Purely combinational so
//                rename can reuse it to predict the same tags.
//  Ports       : i_is_br  [DISP_SIZE]          branch flag per slot
//                i_base   [TAG_W]              tag handed to the first branch
//                o_tag    [DISP_SIZE][TAG_W]   base + #branches in lower slots
//                o_n_br   [clog2(DISP_SIZE+1)] total branches in the group
//  Revision    : 1.0  initial release
// ============================================================================
module msrh_brtag_offset #(
    parameter int BRTAG_NUM = 16,
    parameter int DISP_SIZE = 2
) (
    input  logic [DISP_SIZE-1:0]                          i_is_br,
    input  logic [$clog2(BRTAG_NUM)-1:0]                  i_base,
    output logic [DISP_SIZE-1:0][$clog2(BRTAG_NUM)-1:0]   o_tag,
    output logic [$clog2(DISP_SIZE+1)-1:0]                o_n_br
);

    localparam int TAG_W = $clog2(BRTAG_NUM);
    localparam int CNT_W = $clog2(DISP_SIZE+1);

    logic [CNT_W-1:0] w_cnt;

    // BRTAG_NUM is a power of two, so natural TAG_W-bit wrap is the modulo.
    always_comb begin
        w_cnt = '0;
        o_tag = '0;
        for (int d = 0; d < DISP_SIZE; d++) begin
            o_tag[d] = i_base + TAG_W'(w_cnt);
            w_cnt    = w_cnt + CNT_W'(i_is_br[d]);
        end
        o_n_br = w_cnt;
    end

endmodule
`default_nettype wire

// File: rtl/msrh_brtag_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : msrh_brtag_allocator
//  Description : Dispatch-stage branch-tag allocator. Tags are handed out in
//                circular age order (tail), retired in order from head once
//                resolved, and a mispredict truncates the window to end at
//                the mispredicted tag, freeing every younger tag.
//  Ports       : i_clk, i_reset_n (async, active low)
//                i_disp_valid, i_disp_is_br[DISP_SIZE]  dispatch group
//                o_stall                  not enough free tags for the group
//                o_load[DISP_SIZE]        tag allocated for this slot
//                o_brtag[DISP_SIZE]       allocated tag (0 when not loaded)
//                br_upd (br_upd_if.slave) branch resolution
//                o_free_cnt, o_empty      occupancy status
//  Config      : MSRH_BRTAG_MULTI_RETIRE_EN - retire up to DISP_SIZE
//                consecutive resolved tags per cycle (default: one per cycle)
//  Revision    : 1.0  initial release
// ============================================================================
module msrh_brtag_allocator
    import msrh_pkg::*;
#(
    parameter int BRTAG_NUM = msrh_conf_pkg::RV_BRU_ENTRY_SIZE,
    parameter int DISP_SIZE = msrh_conf_pkg::DISP_SIZE
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset_n,
    input  logic                                          i_disp_valid,
    input  logic [DISP_SIZE-1:0]                          i_disp_is_br,
    output logic                                          o_stall,
    output logic [DISP_SIZE-1:0]                          o_load,
    output logic [DISP_SIZE-1:0][$clog2(BRTAG_NUM)-1:0]   o_brtag,
    br_upd_if.slave                                       br_upd,
    output logic [$clog2(BRTAG_NUM+1)-1:0]                o_free_cnt,
    output logic                                          o_empty
);

    localparam int TAG_W = $clog2(BRTAG_NUM);
    localparam int CNT_W = $clog2(BRTAG_NUM+1);
    localparam int NBR_W = $clog2(DISP_SIZE+1);

    localparam logic [TAG_W-1:0] c_tag_one = TAG_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(BRTAG_NUM);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [BRTAG_NUM-1:0] r_resolved;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [DISP_SIZE-1:0][TAG_W-1:0] w_off;
    logic [NBR_W-1:0]                w_n_br;
    logic [TAG_W-1:0]                w_dist;
    logic                            w_upd_valid;
    logic                            w_flush;
    logic [CNT_W-1:0]                w_free;
    logic                            w_alloc;
    logic [CNT_W-1:0]                w_ret_lim;
    logic [NBR_W-1:0]                w_ret_n;
    logic [TAG_W-1:0]                w_head_nxt;
    logic [TAG_W-1:0]                w_tail_nxt;
    logic [CNT_W-1:0]                w_count_nxt;
    logic [BRTAG_NUM-1:0]            w_resolved_nxt;

    msrh_brtag_offset #(
        .BRTAG_NUM (BRTAG_NUM),
        .DISP_SIZE (DISP_SIZE)
    ) u_offset (
        .i_is_br (i_disp_is_br),
        .i_base  (r_tail),
        .o_tag   (w_off),
        .o_n_br  (w_n_br)
    );

    // A tag is outstanding iff its age distance from head is below count.
    // Using count (not tail) keeps the full case, where head==tail, correct.
    assign w_dist      = br_upd.brtag - r_head;
    assign w_upd_valid = br_upd.update & (CNT_W'(w_dist) < r_count);
    assign w_flush     = w_upd_valid & br_upd.mispredict;

    assign w_free  = c_cnt_max - r_count;
    assign o_stall = i_disp_valid & (CNT_W'(w_n_br) > w_free);
    assign w_alloc = i_disp_valid & ~o_stall & ~w_flush;

    always_comb begin
        o_load  = i_disp_is_br & {DISP_SIZE{w_alloc}};
        o_brtag = '0;
        for (int d = 0; d < DISP_SIZE; d++) begin
            if (o_load[d]) begin
                o_brtag[d] = w_off[d];
            end
        end
    end

    // On a flush only entries up to and including the mispredicted tag
    // remain, so retirement must not run past it.
    assign w_ret_lim = w_flush ? (CNT_W'(w_dist) + c_cnt_one) : r_count;

`ifdef MSRH_BRTAG_MULTI_RETIRE_EN
    // Walk forward from head while entries are in range and resolved.
    always_comb begin
        logic             w_run;
        logic [TAG_W-1:0] w_idx;
        w_run   = 1'b1;
        w_idx   = '0;
        w_ret_n = '0;
        for (int k = 0; k < DISP_SIZE; k++) begin
            w_idx = r_head + TAG_W'(k);
            w_run = w_run & (CNT_W'(k) < w_ret_lim) & r_resolved[w_idx];
            if (w_run) begin
                w_ret_n = w_ret_n + NBR_W'(1);
            end
        end
    end
`else
    assign w_ret_n = NBR_W'((w_ret_lim != '0) && r_resolved[r_head]);
`endif

    always_comb begin
        logic [TAG_W-1:0] w_idx;
        w_idx      = '0;
        w_head_nxt = r_head + TAG_W'(w_ret_n);

        if (w_flush) begin
            w_tail_nxt  = br_upd.brtag + c_tag_one;
            w_count_nxt = CNT_W'(w_dist) + c_cnt_one - CNT_W'(w_ret_n);
        end else if (w_alloc) begin
            w_tail_nxt  = r_tail + TAG_W'(w_n_br);
            w_count_nxt = r_count + CNT_W'(w_n_br) - CNT_W'(w_ret_n);
        end else begin
            w_tail_nxt  = r_tail;
            w_count_nxt = r_count - CNT_W'(w_ret_n);
        end

        // Retired slots are cleared, then the update is recorded, then newly
        // allocated slots are cleared. Allocation only touches free tags, so
        // it can never overlap the update or a retiring entry.
        w_resolved_nxt = r_resolved;
        for (int k = 0; k < DISP_SIZE; k++) begin
            if (NBR_W'(k) < w_ret_n) begin
                w_idx                 = r_head + TAG_W'(k);
                w_resolved_nxt[w_idx] = 1'b0;
            end
        end
        if (w_upd_valid) begin
            w_resolved_nxt[br_upd.brtag] = 1'b1;
        end
        for (int d = 0; d < DISP_SIZE; d++) begin
            if (o_load[d]) begin
                w_resolved_nxt[w_off[d]] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_resolved <= '0;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_resolved <= w_resolved_nxt;
        end
    end

    assign o_free_cnt = w_free;
    assign o_empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_msrh_brtag_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msrh_brtag_allocator
//  Description : Directed self-checking bench, BRTAG_NUM=8, DISP_SIZE=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_msrh_brtag_allocator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       disp_valid;
    logic [1:0] is_br;
    logic       stall;
    logic [1:0] load;
    logic [1:0][2:0] brtag;
    logic [3:0] free_cnt;
    logic       empty;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    br_upd_if #(.TAG_W(3)) upd ();

    msrh_brtag_allocator #(
        .BRTAG_NUM (8),
        .DISP_SIZE (2)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_disp_valid (disp_valid),
        .i_disp_is_br (is_br),
        .o_stall      (stall),
        .o_load       (load),
        .o_brtag      (brtag),
        .br_upd       (upd),
        .o_free_cnt   (free_cnt),
        .o_empty      (empty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid     = 1'b0;
        is_br          = 2'b00;
        upd.update     = 1'b0;
        upd.mispredict = 1'b0;
        upd.brtag      = 3'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [1:0] br);
        disp_valid = 1'b1;
        is_br      = br;
        step();
        idle();
    endtask

    task automatic resolve(input logic [2:0] t, input logic mis);
        upd.update     = 1'b1;
        upd.brtag      = t;
        upd.mispredict = mis;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (free_cnt !== 4'd8) begin n_err++; $display("FAIL reset_free: got %0d want 8", free_cnt); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (load !== 2'b00) begin n_err++; $display("FAIL reset_load: got %b want 00", load); end
        n_cmp++; if (brtag !== 6'd0) begin n_err++; $display("FAIL reset_brtag: got %h want 0", brtag); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_alloc_basic();
        do_reset();
        disp_valid = 1'b1;
        is_br      = 2'b11;
        #1;
        n_cmp++; if (load !== 2'b11) begin n_err++; $display("FAIL basic_load: got %b want 11", load); end
        n_cmp++; if (brtag[0] !== 3'd0) begin n_err++; $display("FAIL basic_tag0: got %0d want 0", brtag[0]); end
        n_cmp++; if (brtag[1] !== 3'd1) begin n_err++; $display("FAIL basic_tag1: got %0d want 1", brtag[1]); end
        step();
        idle();
        #1;
        n_cmp++; if (free_cnt !== 4'd6) begin n_err++; $display("FAIL basic_free: got %0d want 6", free_cnt); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b want 0", empty); end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int g = 0; g < 4; g++) alloc(2'b11);
        disp_valid = 1'b1;
        is_br      = 2'b00;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL full_nobr_stall: got %b want 0", stall); end
        is_br = 2'b01;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL full_stall: got %b want 1", stall); end
        n_cmp++; if (load !== 2'b00) begin n_err++; $display("FAIL full_load: got %b want 00", load); end
        n_cmp++; if (free_cnt !== 4'd0) begin n_err++; $display("FAIL full_free: got %0d want 0", free_cnt); end
        step();
        n_cmp++; if (free_cnt !== 4'd0) begin n_err++; $display("FAIL full_hold_free: got %0d want 0", free_cnt); end
        upd.update = 1'b1;
        upd.brtag  = 3'd0;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL full_resolve_stall: got %b want 1", stall); end
        step();
        upd.update = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL full_preretire_stall: got %b want 1", stall); end
        step();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL wrap_stall: got %b want 0", stall); end
        n_cmp++; if (load !== 2'b01) begin n_err++; $display("FAIL wrap_load: got %b want 01", load); end
        n_cmp++; if (brtag[0] !== 3'd0) begin n_err++; $display("FAIL wrap_tag: got %0d want 0", brtag[0]); end
        n_cmp++; if (free_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_free: got %0d want 1", free_cnt); end
        step();
        idle();
        #1;
        n_cmp++; if (free_cnt !== 4'd0) begin n_err++; $display("FAIL wrap_after_free: got %0d want 0", free_cnt); end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int g = 0; g < 3; g++) alloc(2'b11);
        disp_valid     = 1'b1;
        is_br          = 2'b11;
        upd.update     = 1'b1;
        upd.mispredict = 1'b1;
        upd.brtag      = 3'd2;
        #1;
        n_cmp++; if (load !== 2'b00) begin n_err++; $display("FAIL flush_load: got %b want 00", load); end
        n_cmp++; if (brtag !== 6'd0) begin n_err++; $display("FAIL flush_brtag: got %h want 0", brtag); end
        step();
        idle();
        #1;
        n_cmp++; if (free_cnt !== 4'd5) begin n_err++; $display("FAIL flush_free: got %0d want 5", free_cnt); end
        disp_valid = 1'b1;
        is_br      = 2'b01;
        #1;
        n_cmp++; if (load !== 2'b01) begin n_err++; $display("FAIL flush_next_load: got %b want 01", load); end
        n_cmp++; if (brtag[0] !== 3'd3) begin n_err++; $display("FAIL flush_next_tag: got %0d want 3", brtag[0]); end
        step();
        idle();
        #1;
        n_cmp++; if (free_cnt !== 4'd4) begin n_err++; $display("FAIL flush_next_free: got %0d want 4", free_cnt); end
    endtask

    task automatic test_ooo_resolve();
        do_reset();
        alloc(2'b11);
        alloc(2'b01);
        resolve(3'd1, 1'b0);
        resolve(3'd2, 1'b0);
        #1;
        n_cmp++; if (free_cnt !== 4'd5) begin n_err++; $display("FAIL ooo_noretire: got %0d want 5", free_cnt); end
        resolve(3'd0, 1'b0);
        #1;
        n_cmp++; if (free_cnt !== 4'd5) begin n_err++; $display("FAIL ooo_e1: got %0d want 5", free_cnt); end
        step();
`ifdef MSRH_BRTAG_MULTI_RETIRE_EN
        n_cmp++; if (free_cnt !== 4'd7) begin n_err++; $display("FAIL ooo_e2: got %0d want 7", free_cnt); end
`else
        n_cmp++; if (free_cnt !== 4'd6) begin n_err++; $display("FAIL ooo_e2: got %0d want 6", free_cnt); end
`endif
        step();
`ifdef MSRH_BRTAG_MULTI_RETIRE_EN
        n_cmp++; if (free_cnt !== 4'd8) begin n_err++; $display("FAIL ooo_e3: got %0d want 8", free_cnt); end
`else
        n_cmp++; if (free_cnt !== 4'd7) begin n_err++; $display("FAIL ooo_e3: got %0d want 7", free_cnt); end
`endif
        step();
        n_cmp++; if (free_cnt !== 4'd8) begin n_err++; $display("FAIL ooo_e4: got %0d want 8", free_cnt); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ooo_empty: got %b want 1", empty); end
        // Empty window: a mispredict on tag 5 is out of range and ignored,
        // so the same-cycle group allocates normally at tail=3.
        disp_valid     = 1'b1;
        is_br          = 2'b01;
        upd.update     = 1'b1;
        upd.mispredict = 1'b1;
        upd.brtag      = 3'd5;
        #1;
        n_cmp++; if (load !== 2'b01) begin n_err++; $display("FAIL stale_load: got %b want 01", load); end
        n_cmp++; if (brtag[0] !== 3'd3) begin n_err++; $display("FAIL stale_tag: got %0d want 3", brtag[0]); end
        step();
        idle();
        #1;
        n_cmp++; if (free_cnt !== 4'd7) begin n_err++; $display("FAIL stale_free: got %0d want 7", free_cnt); end
    endtask

    task automatic test_slot1_only();
        do_reset();
        alloc(2'b11);
        disp_valid = 1'b1;
        is_br      = 2'b10;
        #1;
        n_cmp++; if (load !== 2'b10) begin n_err++; $display("FAIL slot1_load: got %b want 10", load); end
        n_cmp++; if (brtag[1] !== 3'd2) begin n_err++; $display("FAIL slot1_tag1: got %0d want 2", brtag[1]); end
        n_cmp++; if (brtag[0] !== 3'd0) begin n_err++; $display("FAIL slot1_tag0: got %0d want 0", brtag[0]); end
        step();
        idle();
        #1;
        n_cmp++; if (free_cnt !== 4'd5) begin n_err++; $display("FAIL slot1_free: got %0d want 5", free_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc(2'b11);
        alloc(2'b11);
        alloc(2'b01);
        #1;
        n_cmp++; if (free_cnt !== 4'd3) begin n_err++; $display("FAIL areset_pre_free: got %0d want 3", free_cnt); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (free_cnt !== 4'd8) begin n_err++; $display("FAIL areset_free: got %0d want 8", free_cnt); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL areset_empty: got %b want 1", empty); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alloc_basic();
        test_full_stall();
        test_mispredict();
        test_ooo_resolve();
        test_slot1_only();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msrh_brtag_allocator.md
Name: msrh_brtag_allocator

Overview:
- Dispatch-stage branch-tag allocator.
- Hands out branch tags (brtag_t) in circular age order to branch instructions in each dispatch group.
- Drives i_load / i_brtag of the per-branch rename snapshot store.
- Reclaims tags on branch resolution. On a mispredict, bulk-frees every tag younger than the mispredicted branch.

Parameters:
- BRTAG_NUM, default msrh_conf_pkg::RV_BRU_ENTRY_SIZE (16): number of tags/snapshots; must be a power of 2.
- DISP_SIZE, default msrh_conf_pkg::DISP_SIZE (2): dispatch slots per group.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_disp_valid  in  1  dispatch group valid.
- i_disp_is_br  in  DISP_SIZE (grp_id_t)  per-slot branch flag.
- o_stall  out  1  insufficient free tags; group must be held.
- o_load  out  DISP_SIZE (grp_id_t)  per-slot tag allocated this cycle.
- o_brtag  out  DISP_SIZE x BRTAG_W  allocated tag per slot; 0 where o_load is 0.
- br_upd_if.slave  modport  —  fields used: update, brtag, mispredict.
- o_free_cnt  out  clog2(BRTAG_NUM+1)  free tags (registered).
- o_empty  out  1  no tags outstanding.

Behaviour:
- State:
  - r_head and r_tail: BRTAG_W bits each, wrap naturally.
  - r_count: clog2(BRTAG_NUM+1) bits, outstanding tags.
  - r_resolved: BRTAG_NUM bits.
- Reset (async): head=tail=count=0, resolved=0. o_free_cnt=BRTAG_NUM, o_empty=1, o_stall=0, o_load=0, o_brtag all 0.
- n_br = popcount(i_disp_is_br).
- o_stall: combinational, = i_disp_valid & (n_br > BRTAG_NUM - r_count).
- Allocation, same cycle (0-cycle latency):
  - For slot d: o_load[d] = i_disp_valid & i_disp_is_br[d] & ~o_stall & ~flush.
  - o_brtag[d] = r_tail + popcount(i_disp_is_br[d-1:0]), mod BRTAG_NUM.
  - Next cycle: tail += n_br and resolved[new tags] cleared.
  - o_stall is all-or-nothing: no partial allocation within a group.
- Correct resolve (update & ~mispredict): set resolved[brtag].
- Retire:
  - If count>0 and resolved[head]: head++, count--, resolved[head] cleared.
  - At most one retire per cycle.
- Mispredict (update & mispredict, tag t) = flush:
  - tail := t+1.
  - resolved[t] := 1.
  - count := ((t - head) mod BRTAG_NUM) + 1, minus 1 if head retires this same cycle.
  - All tags younger than t are freed.
  - Any same-cycle dispatch is suppressed (flush wins; o_load=0).
- Simultaneous allocate and retire: count_next = count + n_br - retire.
- Full (count==BRTAG_NUM): any group with n_br>0 stalls; a group with no branches passes.
- Empty: o_empty=1 and no retire occurs.
- Update for a tag outside [head, tail): ignored, no state change.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously.
- o_free_cnt = BRTAG_NUM - r_count. o_empty = (r_count==0).

Optional Feature:
MSRH_BRTAG_MULTI_RETIRE_EN:
- Defined: retire up to DISP_SIZE consecutive resolved entries from head per cycle; stop at the first unresolved entry or at tail.
- Undefined: single retire per cycle, as above.
- Allocation behaviour and the mispredict rule are identical in both builds.

Decomposition:
- msrh_pkg:
  - brtag_t, BRTAG_W = $clog2(BRTAG_NUM).
  - grp_id_t.
  - br_upd_if field definitions.
- Sub-module msrh_brtag_offset: per-slot prefix-popcount and modular tag-offset generator; combinational, reusable by rename.

Test Plan (BRTAG_NUM=8, DISP_SIZE=2):
- Reset, then group valid with is_br=2'b11 → o_load=2'b11, o_brtag={1,0}; next cycle o_free_cnt=6.
- Allocate 4 groups of 2 branches; then a group with is_br=2'b01 → o_stall=1, o_load=0, tail unchanged. Resolve tag 0 → tag 0 retires next cycle; the held group then gets tag 0 (wrap-around).
- Allocate tags 0..5; mispredict tag 2 with a same-cycle group is_br=2'b11 → o_load=0; next cycle count=3, free=5, next allocation returns tag 3.
- Resolve tags 1 and 2 before tag 0 → no retire; resolve tag 0 → count drops by 1/cycle over 3 cycles (or 2+1 cycles with MSRH_BRTAG_MULTI_RETIRE_EN).
- Group with is_br=2'b10 → o_load=2'b10, o_brtag[1]=tail, o_brtag[0]=0.
- Assert i_reset_n low with 5 tags outstanding → o_free_cnt=8 and o_empty=1 immediately, without a clock edge.
